// File: rtl/icache_fetch_responder_if.sv
// Fetch-side and RAM-side signals of the instruction cache responder.
// The slave modport is the responder's view; master is the surrounding fetch stage and RAM.
interface icache_fetch_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_fetch_responder.sv
// Direct-mapped, read-only instruction cache with one word per frame.
// A miss latches the word address and holds a RAM read until the wait-state bus completes.
module icache_fetch_responder #(
    parameter int unsigned SETS = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    icache_fetch_responder_if.slave   bus
);
    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e             state_q;
    logic               iren_q;
    logic [29:0]        miss_q;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS];

    logic [IDX-1:0]     req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX-1:0]     miss_idx;
    logic               hit;
    logic               unused_byte_bits;

    assign req_idx          = bus.imemaddr[IDX+1:2];
    assign req_tag          = bus.imemaddr[31:IDX+2];
    assign miss_idx         = miss_q[IDX-1:0];
    assign unused_byte_bits = ^bus.imemaddr[1:0];

    // Lookups are only served in IDLE; a flush cycle never hits.
    assign hit = bus.imemREN && (state_q == StIdle) && !bus.iflush &&
                 valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? data_q[req_idx] : 32'h0;
    assign bus.iREN     = iren_q;
    assign bus.iaddr    = {miss_q, 2'b00};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            iren_q  <= 1'b0;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.iflush) begin
                        valid_q <= '0;
                    end else if (bus.imemREN && !hit) begin
                        miss_q  <= bus.imemaddr[31:2];
                        iren_q  <= 1'b1;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    // Flush beats completion: the frame stays unwritten.
                    if (bus.iflush) begin
                        valid_q <= '0;
                        iren_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (!bus.iwait) begin
                        valid_q[miss_idx] <= 1'b1;
                        tag_q[miss_idx]   <= miss_q[29:IDX];
                        data_q[miss_idx]  <= bus.iload;
                        iren_q            <= 1'b0;
                        state_q           <= StIdle;
                    end
                end
                default: begin
                    iren_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed vector table, hand-written corner sequences and random traffic
// checked against a word-address cache model.
module tb_icache_fetch_responder;
    localparam int unsigned SETS = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_fetch_responder_if bus();

    icache_fetch_responder #(.SETS(SETS)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        ren;
        logic [31:0] addr;
        logic        flush;
        logic        iwait;
        logic [31:0] iload;
        logic        hit;
        logic [31:0] load;
        logic        iren;
        logic [31:0] iaddr;
    } vec_t;

    vec_t vecs[$];

    // Model: frame index -> cached word address and data; pending fill as a queue.
    logic [29:0] m_waddr [int];
    logic [31:0] m_data  [int];
    logic [29:0] m_pend  [$];
    logic [29:0] m_latched;

    function automatic vec_t mk(logic r, logic ren, logic [31:0] a, logic f, logic w,
                                logic [31:0] ld, logic h, logic [31:0] el, logic ir,
                                logic [31:0] ia);
        vec_t v;
        v.rst = r; v.ren = ren; v.addr = a; v.flush = f; v.iwait = w; v.iload = ld;
        v.hit = h; v.load = el; v.iren = ir; v.iaddr = ia;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_hit();
        int idx;
        logic [29:0] w;
        w   = bus.imemaddr[31:2];
        idx = int'(w % SETS);
        return bus.imemREN && !bus.iflush && (m_pend.size() == 0) &&
               m_waddr.exists(idx) && (m_waddr[idx] == w);
    endfunction

    task automatic model_update();
        logic [29:0] w;
        if (rst) begin
            m_waddr.delete();
            m_data.delete();
            m_pend.delete();
            m_latched = '0;
        end else if (m_pend.size() != 0) begin
            if (bus.iflush) begin
                m_waddr.delete();
                m_data.delete();
                m_pend.delete();
            end else if (!bus.iwait) begin
                w = m_pend.pop_front();
                m_waddr[int'(w % SETS)] = w;
                m_data[int'(w % SETS)]  = bus.iload;
            end
        end else if (bus.iflush) begin
            m_waddr.delete();
            m_data.delete();
        end else if (bus.imemREN && !model_hit()) begin
            m_latched = bus.imemaddr[31:2];
            m_pend.push_back(m_latched);
        end
    endtask

    // mode 0: no check, 1: check against vector v, 2: check against model
    task automatic step(input int mode, input vec_t v, input string tag);
        logic        eh;
        logic [31:0] el;
        rst          = v.rst;
        bus.imemREN  = v.ren;
        bus.imemaddr = v.addr;
        bus.iflush   = v.flush;
        bus.iwait    = v.iwait;
        bus.iload    = v.iload;
        @(negedge clk);
        if (mode == 1) begin
            chk({tag, " ihit"}, 32'(bus.ihit), 32'(v.hit));
            chk({tag, " imemload"}, bus.imemload, v.load);
            chk({tag, " iREN"}, 32'(bus.iREN), 32'(v.iren));
            chk({tag, " iaddr"}, bus.iaddr, v.iaddr);
        end else if (mode == 2) begin
            eh = model_hit();
            el = eh ? m_data[int'(bus.imemaddr[31:2] % SETS)] : 32'h0;
            chk({tag, " ihit"}, 32'(bus.ihit), 32'(eh));
            chk({tag, " imemload"}, bus.imemload, el);
            chk({tag, " iREN"}, 32'(bus.iREN), 32'(m_pend.size() != 0));
            chk({tag, " iaddr"}, bus.iaddr, {m_latched, 2'b00});
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic mstep(input logic r, input logic ren, input logic [31:0] a,
                         input logic f, input logic w, input logic [31:0] ld,
                         input string tag);
        step(2, mk(r, ren, a, f, w, ld, 1'b0, 32'h0, 1'b0, 32'h0), tag);
    endtask

    initial begin
        vec_t v;
        m_latched = '0;
        // rst ren addr flush iwait iload | hit load iren iaddr
        vecs.push_back(mk(1, 1, 32'h00, 0, 1, 32'h0,        0, 32'h0,        0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 32'hDEADBEEF, 0, 32'h0,        1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 32'hDEADBEEF, 0, 32'h0,        1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h02, 0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h00));
        vecs.push_back(mk(0, 0, 32'h00, 0, 1, 32'h0,        0, 32'h0,        0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h40, 0, 0, 32'h12345678, 0, 32'h0,        0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h40, 0, 0, 32'h12345678, 0, 32'h0,        1, 32'h40));
        vecs.push_back(mk(0, 1, 32'h40, 0, 0, 32'h0,        1, 32'h12345678, 0, 32'h40));
        vecs.push_back(mk(0, 1, 32'h00, 0, 0, 32'h0,        0, 32'h0,        0, 32'h40));
        vecs.push_back(mk(0, 1, 32'h00, 0, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 1, 1, 32'h0,        0, 32'h0,        0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 32'h0,        0, 32'h0,        0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 32'h0,        0, 32'h0,        1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 1, 0, 32'h55555555, 0, 32'h0,        1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 0, 32'h0,        0, 32'h0,        0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 0, 32'hCAFEF00D, 0, 32'h0,        1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 32'h0,        1, 32'hCAFEF00D, 0, 32'h00));

        v = mk(1, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 0, 32'h0);
        step(0, v, "init");
        step(0, v, "init");
        for (int i = 0; i < vecs.size(); i++) begin
            step(1, vecs[i], $sformatf("vec%0d", i));
        end

        // Address change and request drop mid-fill.
        mstep(0, 1, 32'h08, 0, 1, 32'h0, "t5a");
        mstep(0, 1, 32'h04, 0, 1, 32'h0, "t5b");
        mstep(0, 0, 32'h04, 0, 1, 32'h0, "t5c");
        mstep(0, 1, 32'h04, 0, 1, 32'h0, "t5d");
        mstep(0, 1, 32'h04, 0, 0, 32'h11112222, "t5e");
        mstep(0, 1, 32'h08, 0, 1, 32'h0, "t5f");
        chk("t5 iaddr held", bus.iaddr, 32'h08);
        mstep(0, 1, 32'h04, 0, 1, 32'h0, "t5g");
        mstep(0, 1, 32'h04, 0, 0, 32'h33334444, "t5h");
        mstep(0, 1, 32'h04, 0, 1, 32'h0, "t5i");

        // Reset during a fill clears every frame.
        mstep(0, 1, 32'h0C, 0, 1, 32'h0, "t6a");
        mstep(0, 1, 32'h0C, 0, 1, 32'h0, "t6b");
        mstep(1, 1, 32'h0C, 0, 1, 32'h0, "t6c");
        chk("t6 iREN after reset", 32'(bus.iREN), 32'h0);
        mstep(0, 1, 32'h00, 0, 1, 32'h0, "t6d");
        chk("t6 0x0 misses", 32'(bus.iREN), 32'h1);
        mstep(0, 1, 32'h00, 0, 0, 32'h77778888, "t6e");
        mstep(0, 1, 32'h00, 0, 1, 32'h0, "t6f");

        for (int i = 0; i < 600; i++) begin
            mstep(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  {22'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 2'b00} >> 2,
                  ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, $urandom(),
                  "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
